keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner that replaces the fixed 4x4 column-strobe decoder feeding the game's coordinate-entry logic. It drives the keypad columns one at a time, samples the rows through a synchroniser, and debounces over whole scan frames. Each debounced press produces one registered key code and a single-cycle `key_valid` strobe. It sits between the keypad pins and the shot-entry FSM; the FSM consumes `key`/`key_valid` instead of polling a level-only code.

## Interface
- `ROWS`, 4, number of row inputs (2..8)
- `COLS`, 4, number of column outputs (2..8)
- `SCAN_DIV`, 50000, clock cycles each column is driven (>= 4)
- `DEBOUNCE_FRAMES`, 4, consecutive identical frames required to accept a press or a release (1..15)
- `USE_PMOD_MAP`, 1, selects the keymap: 1 = Pmod KYPD code table (legal only when ROWS = COLS = 4); 0 = linear index
- `REPEAT_FRAMES`, 32, frames between auto-repeat strobes (used only with the macro)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `row`  in  ROWS  keypad rows; active-low, pulled up externally
- `col`  out  COLS  column drive; active-low, exactly one bit low at all times
- `key`  out  KW = $clog2(ROWS*COLS)  code of the last accepted key; holds its value after release
- `key_valid`  out  1  one-cycle strobe when `key` is updated
- `key_down`  out  1  debounced "a key is held"
- `multi_key`  out  1  last completed frame saw more than one key pressed

## Operation
- Column counter `c` advances 0..COLS-1 and wraps. Each column is driven for SCAN_DIV cycles: `col = ~(1 << c)`.
- `row` passes through a two-flop synchroniser. It is sampled on the last cycle of each column dwell, so the line has SCAN_DIV-1 cycles to settle.
- One frame is COLS dwells. The frame result is computed at the frame's last sample:
  - The pressed key is the first pressed bit in scan order (c ascending, then row ascending). Index = r*COLS + c.
  - `none` means no bit was pressed in the frame.
  - `multi_key` is set if two or more bits were pressed.
- Key code mapping:
  - USE_PMOD_MAP = 0: code = index.
  - USE_PMOD_MAP = 1: code = package table value (hex digits 0..F in Pmod KYPD layout).
- Debounce FSM, evaluated once per frame end:
  - IDLE: a frame with a key loads the candidate, sets cnt = 1, and goes to PRESS_WAIT.
  - PRESS_WAIT:
    - Frame with the same candidate: cnt++. When cnt reaches DEBOUNCE_FRAMES, register `key`, pulse `key_valid`, set `key_down` = 1, go to HELD.
    - Frame with a different key: reload the candidate, cnt = 1.
    - Frame with none: return to IDLE.
  - HELD: a frame that does not show the held key goes to REL_WAIT with cnt = 1. A different key counts as a release.
  - REL_WAIT:
    - Frame without the held key: cnt++. When cnt reaches DEBOUNCE_FRAMES, set `key_down` = 0 and go to IDLE.
    - Frame showing the held key again: back to HELD, no new strobe.
- A new key is accepted only after the previous key has been released. Rolling from one key to another needs a full release debounce followed by a press debounce.
- With DEBOUNCE_FRAMES = 1, a single frame accepts a press or a release.

## Timing
- Reset values: `col` = all ones except bit 0 low; `key` = 0; `key_valid` = 0; `key_down` = 0; `multi_key` = 0; FSM = IDLE; all counters = 0.
- Reset asserted mid-frame or mid-debounce discards all progress. Scanning restarts at column 0 on the first cycle after `rst` falls.
- Frame length is COLS*SCAN_DIV cycles.
- `key_valid` rises the cycle after the frame-end sample that completes the debounce. `key` changes in that same cycle.
- Latency from a stable press reaching the synchroniser input: at most (DEBOUNCE_FRAMES+1)*COLS*SCAN_DIV + 3 cycles.
- `key_valid` is never high two cycles in a row. Successive strobes are at least one frame apart.
- `multi_key` updates once per frame end, registered.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD, a frame counter restarts at each strobe. Every REPEAT_FRAMES frames of continuous HELD, `key_valid` pulses again with the same `key`. The counter clears on leaving HELD. Entering REL_WAIT pauses it, and returning to HELD resumes it.
- `KEYPAD_REPEAT_EN` not defined: exactly one strobe per press; REPEAT_FRAMES is ignored and its logic is absent.

## Structure
- Shared package `keypad_pkg` holds:
  - the 16-entry Pmod KYPD keymap constant indexed by r*4+c;
  - the debounce state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT);
  - a function returning KW for given ROWS/COLS.
- One sub-module, `keypad_debounce`: the frame-level FSM plus the counters and the repeat logic. The top level owns column strobe, synchroniser, frame reduction and keymap.

## Test plan
All scenarios use ROWS = COLS = 4, SCAN_DIV = 4, DEBOUNCE_FRAMES = 3, so one frame is 16 cycles.
- Reset, then idle for 64 cycles -> `col` cycles 1110, 1101, 1011, 0111, changing every 4 cycles; `key_valid` stays 0 throughout.
- Press r1c2 continuously with USE_PMOD_MAP = 0 -> one `key_valid` with `key` = 6, within 3 frames + 3 cycles; `key_down` = 1; no further strobe while held (macro off).
- Bounce r0c0 for 1 frame, release, then press r0c0 stably -> exactly one strobe, with `key` equal to table entry 0 (USE_PMOD_MAP = 1).
- Press r2c1 and r3c3 together -> `multi_key` = 1 and `key` = index 9 (first in scan order).
- Assert `rst` during PRESS_WAIT at cnt = 2 -> no strobe; scanning restarts at column 0; re-debounce needs 3 fresh frames.
- With KEYPAD_REPEAT_EN and REPEAT_FRAMES = 2, hold r3c0 for 10 frames -> initial strobe, then one strobe every 2 frames with `key` = 12.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: keymap, debounce states and width helper shared by the
// keypad scanner; auto-repeat is built only with KEYPAD_REPEAT_EN.
package keypad_pkg;

  typedef logic [1:0] db_state_t;

  localparam db_state_t IDLE       = 2'd0;
  localparam db_state_t PRESS_WAIT = 2'd1;
  localparam db_state_t HELD       = 2'd2;
  localparam db_state_t REL_WAIT   = 2'd3;

  // Pmod KYPD legends, indexed by r*4+c
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic int kw_of(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level press/release debounce FSM; the
// auto-repeat counter exists only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int KW              = 4,
  parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_FRAMES   = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_end,
  input  logic          frame_hit,
  input  logic [KW-1:0] frame_code,
  output logic [KW-1:0] key,
  output logic          key_valid,
  output logic          key_down
);

  localparam logic [3:0] DLIM = 4'(DEBOUNCE_FRAMES);

  db_state_t     state, state_n;
  logic [KW-1:0] cand, cand_n;
  logic [3:0]    cnt, cnt_n;
  logic          same_cand;
  logic          shows_key;
  logic          cnt_done;
  logic          accept;
  logic          rel;
  logic          strobe;

  assign same_cand = frame_hit && (frame_code == cand);
  assign shows_key = frame_hit && (frame_code == key);
  // cnt is zero in IDLE and HELD, so this also covers DEBOUNCE_FRAMES=1
  assign cnt_done  = (cnt + 4'd1) >= DLIM;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    rel     = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (frame_hit) begin
            cand_n  = frame_code;
            cnt_n   = 4'd1;
            state_n = PRESS_WAIT;
            accept  = cnt_done;
          end
        end
        PRESS_WAIT: begin
          if (!frame_hit) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else if (!same_cand) begin
            cand_n = frame_code;
            cnt_n  = 4'd1;
          end else begin
            cnt_n  = cnt + 4'd1;
            accept = cnt_done;
          end
        end
        HELD: begin
          if (!shows_key) begin
            cnt_n   = 4'd1;
            state_n = REL_WAIT;
            rel     = cnt_done;
          end
        end
        REL_WAIT: begin
          if (shows_key) begin
            cnt_n   = '0;
            state_n = HELD;
          end else begin
            cnt_n = cnt + 4'd1;
            rel   = cnt_done;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (accept) begin
      cnt_n   = '0;
      state_n = HELD;
    end
    if (rel) begin
      cnt_n   = '0;
      state_n = IDLE;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);

  logic [RW-1:0] rep;
  logic          rep_tick;
  logic          rep_fire;

  assign rep_tick = frame_end && (state == HELD) && shows_key;
  assign rep_fire = rep_tick && ((rep + RW'(1)) >= RW'(REPEAT_FRAMES));
  assign strobe   = accept | rep_fire;

  // paused while in REL_WAIT, cleared once the key is released
  always_ff @(posedge clk) begin
    if (rst) begin
      rep <= '0;
    end else if (accept || rel || rep_fire) begin
      rep <= '0;
    end else if (rep_tick) begin
      rep <= rep + RW'(1);
    end
  end
`else
  assign strobe = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= strobe;
      if (accept) begin
        key      <= cand_n;
        key_down <= 1'b1;
      end else if (rel) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column strobe, row synchroniser, frame reduction and
// keymap for a matrix keypad; KEYPAD_REPEAT_EN enables auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS            = 4,
  parameter  int COLS            = 4,
  parameter  int SCAN_DIV        = 50000,
  parameter  int DEBOUNCE_FRAMES = 4,
  parameter  int USE_PMOD_MAP    = 1,
  parameter  int REPEAT_FRAMES   = 32,
  localparam int KW              = kw_of(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key,
  output logic            key_valid,
  output logic            key_down,
  output logic            multi_key
);

  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CLAST = CW'(COLS - 1);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);

  logic [CW-1:0]   c;
  logic [DW-1:0]   div;
  logic [ROWS-1:0] row_s1, row_s2;
  logic [ROWS-1:0] pressed;
  logic            sample, last_col, frame_end;
  logic            acc_hit, acc_multi;
  logic [KW-1:0]   acc_idx;
  logic            cur_hit, cur_multi;
  logic [KW-1:0]   cur_idx;
  logic            frm_hit, frm_multi;
  logic [KW-1:0]   frm_idx, frm_code;

  assign sample    = (div == DLAST);
  assign last_col  = (c == CLAST);
  assign frame_end = sample & last_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      div <= '0;
      col <= ~COLS'(1);
    end else if (sample) begin
      div <= '0;
      c   <= last_col ? '0 : c + CW'(1);
      col <= {col[COLS-2:0], col[COLS-1]};
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign pressed = ~row_s2;

  // lowest pressed row of the current column wins
  always_comb begin
    cur_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pressed[r]) cur_idx = KW'(r * COLS + int'(c));
    end
  end

  assign cur_hit   = |pressed;
  assign cur_multi = |(pressed & (pressed - ROWS'(1)));
  assign frm_hit   = acc_hit | cur_hit;
  assign frm_idx   = acc_hit ? acc_idx : cur_idx;
  assign frm_multi = acc_multi | cur_multi | (acc_hit & cur_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_idx   <= '0;
      multi_key <= 1'b0;
    end else if (sample) begin
      if (last_col) begin
        acc_hit   <= 1'b0;
        acc_multi <= 1'b0;
        acc_idx   <= '0;
        multi_key <= frm_multi;
      end else begin
        acc_hit   <= frm_hit;
        acc_multi <= frm_multi;
        acc_idx   <= frm_idx;
      end
    end
  end

  generate
    if (USE_PMOD_MAP != 0) begin : g_pmod
      assign frm_code = KW'(KEYMAP[frm_idx[3:0]]);
    end else begin : g_lin
      assign frm_code = frm_idx;
    end
  endgenerate

  keypad_debounce #(
    .KW              (KW),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_FRAMES   (REPEAT_FRAMES)
`endif
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .frame_end  (frame_end),
    .frame_hit  (frm_hit),
    .frame_code (frm_code),
    .key        (key),
    .key_valid  (key_valid),
    .key_down   (key_down)
  );

endmodule
